// File: rtl/block_mean_calc.sv
// block_mean_calc: accumulates the active RGB stream over an H_BLOCKS x V_BLOCKS
// zone grid and emits each block row's per-channel means as a burst of words.
// Means are taken with a reciprocal multiply and a rounding shift, so no divider.
module block_mean_calc #(
  parameter int H_ACT    = 1280,
  parameter int V_ACT    = 720,
  parameter int H_BLOCKS = 8,
  parameter int V_BLOCKS = 5,
  parameter int RECIP    = 728,
  parameter int SHIFT    = 24
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        vs,
  input  logic        de,
  input  logic [23:0] rgb,
  output logic [23:0] block_mean,
  output logic        data_vaild,
  output logic [5:0]  block_v_cnt,
  output logic [5:0]  block_h_cnt
);

  localparam int BW  = H_ACT / H_BLOCKS;
  localparam int BH  = V_ACT / V_BLOCKS;
  localparam int XW  = $clog2(H_ACT + 1);
  localparam int YW  = $clog2(V_ACT + 1);
  localparam int BXW = $clog2(BW + 1);
  localparam int BYW = $clog2(BH + 1);
  localparam logic [33:0] RECIP_W = 34'(RECIP);
  localparam logic [34:0] HALF    = 35'd1 << (SHIFT - 1);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_EMIT = 1'b1} state_t;

  // Zero-extended 8-bit channel k of a packed pixel (0=B, 1=G, 2=R).
  function automatic logic [23:0] chan(input logic [23:0] p, input int k);
    return {16'h0000, p[8*k +: 8]};
  endfunction

  // Rounding shift of a scaled product, saturated to one 8-bit channel.
  function automatic logic [7:0] sat_round(input logic [33:0] p);
    logic [34:0] s;
    s = ({1'b0, p} + HALF) >> SHIFT;
    if (s > 35'd255) return 8'hFF;
    else return s[7:0];
  endfunction

  logic           r_de_d;
  logic [XW-1:0]  r_x;
  logic [YW-1:0]  r_y;
  logic [BXW-1:0] r_bx;
  logic [5:0]     r_col;
  logic [BYW-1:0] r_by;
  logic [5:0]     r_row;
  logic [23:0]    r_acc    [H_BLOCKS][3];
  logic [23:0]    r_shadow [H_BLOCKS][3];
  state_t         r_state;
  state_t         w_next;
  logic           w_emit;
  logic [5:0]     r_idx;
  logic [5:0]     r_row_lat;
  logic [23:0]    w_sel [3];
  logic           r_s1_vld;
  logic [5:0]     r_s1_h;
  logic [5:0]     r_s1_v;
  logic [33:0]    r_prod [3];
  logic           w_pix;
  logic           w_row_done;
  logic           w_de_fall;

  // A pixel counts only inside the active window and outside vsync.
  assign w_pix      = de && !vs && (r_x < XW'(H_ACT)) && (r_y < YW'(V_ACT));
  assign w_row_done = w_pix && (r_x == XW'(H_ACT - 1)) && (r_by == BYW'(BH - 1));
  assign w_de_fall  = r_de_d && !de;

  // Line/pixel position and incremental zone column/row tracking.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      r_de_d <= 1'b0;
      r_x    <= '0;
      r_y    <= '0;
      r_bx   <= '0;
      r_col  <= 6'd0;
      r_by   <= '0;
      r_row  <= 6'd0;
    end else begin
      r_de_d <= de;
      if (vs) begin
        r_x   <= '0;
        r_y   <= '0;
        r_bx  <= '0;
        r_col <= 6'd0;
        r_by  <= '0;
        r_row <= 6'd0;
      end else if (w_de_fall) begin
        r_x   <= '0;
        r_bx  <= '0;
        r_col <= 6'd0;
        if (r_y < YW'(V_ACT)) begin
          r_y <= r_y + YW'(1);
          if (r_by == BYW'(BH - 1)) begin
            r_by  <= '0;
            r_row <= (r_row == 6'(V_BLOCKS - 1)) ? 6'd0 : r_row + 6'd1;
          end else begin
            r_by <= r_by + BYW'(1);
          end
        end
      end else if (w_pix) begin
        r_x <= r_x + XW'(1);
        if (r_bx == BXW'(BW - 1)) begin
          r_bx  <= '0;
          r_col <= (r_col == 6'(H_BLOCKS - 1)) ? 6'd0 : r_col + 6'd1;
        end else begin
          r_bx <= r_bx + BXW'(1);
        end
      end
    end
  end

  // Zone accumulators; emptied on vsync and when a finished row moves to the shadow bank.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < H_BLOCKS; c++)
        for (int k = 0; k < 3; k++) r_acc[c][k] <= 24'd0;
    end else if (vs || w_row_done) begin
      for (int c = 0; c < H_BLOCKS; c++)
        for (int k = 0; k < 3; k++) r_acc[c][k] <= 24'd0;
    end else if (w_pix) begin
      for (int c = 0; c < H_BLOCKS; c++)
        for (int k = 0; k < 3; k++)
          if (r_col == 6'(c)) r_acc[c][k] <= r_acc[c][k] + chan(rgb, k);
    end
  end

  // Shadow bank captures the finished row, folding in the row-done pixel itself.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < H_BLOCKS; c++)
        for (int k = 0; k < 3; k++) r_shadow[c][k] <= 24'd0;
    end else if (w_row_done) begin
      for (int c = 0; c < H_BLOCKS; c++)
        for (int k = 0; k < 3; k++)
          r_shadow[c][k] <= r_acc[c][k] + ((r_col == 6'(c)) ? chan(rgb, k) : 24'd0);
    end
  end

  // Emit FSM state register.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Emit FSM next state: one burst of H_BLOCKS words per row-done event.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: w_next = w_row_done ? ST_EMIT : ST_IDLE;
      ST_EMIT: w_next = (r_idx == 6'(H_BLOCKS - 1)) ? ST_IDLE : ST_EMIT;
      default: w_next = ST_IDLE;
    endcase
  end

  // Emit FSM output: column slot issued into the arithmetic pipeline.
  always_comb begin
    w_emit = 1'b0;
    case (r_state)
      ST_IDLE: w_emit = 1'b0;
      ST_EMIT: w_emit = 1'b1;
      default: w_emit = 1'b0;
    endcase
  end

  // Burst column index and the latched row of the event.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      r_idx     <= 6'd0;
      r_row_lat <= 6'd0;
    end else if ((r_state == ST_IDLE) && w_row_done) begin
      r_idx     <= 6'd0;
      r_row_lat <= r_row;
    end else if (w_emit) begin
      r_idx <= (r_idx == 6'(H_BLOCKS - 1)) ? 6'd0 : r_idx + 6'd1;
    end
  end

  // Select the shadow column addressed by the burst index.
  always_comb begin
    for (int k = 0; k < 3; k++) w_sel[k] = 24'd0;
    for (int c = 0; c < H_BLOCKS; c++)
      if (r_idx == 6'(c))
        for (int k = 0; k < 3; k++) w_sel[k] = r_shadow[c][k];
  end

  // Stage 1: scale each channel sum by the reciprocal of the zone area.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      r_s1_vld <= 1'b0;
      r_s1_h   <= 6'd0;
      r_s1_v   <= 6'd0;
      for (int k = 0; k < 3; k++) r_prod[k] <= 34'd0;
    end else begin
      r_s1_vld <= w_emit;
      if (w_emit) begin
        r_s1_h <= r_idx;
        r_s1_v <= r_row_lat;
        for (int k = 0; k < 3; k++) r_prod[k] <= {10'd0, w_sel[k]} * RECIP_W;
      end
    end
  end

  // Stage 2: round, saturate and register the outputs; they hold between strobes.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      data_vaild  <= 1'b0;
      block_mean  <= 24'd0;
      block_h_cnt <= 6'd0;
      block_v_cnt <= 6'd0;
    end else begin
      data_vaild <= r_s1_vld;
      if (r_s1_vld) begin
        block_mean  <= {sat_round(r_prod[2]), sat_round(r_prod[1]), sat_round(r_prod[0])};
        block_h_cnt <= r_s1_h;
        block_v_cnt <= r_s1_v;
      end
    end
  end

endmodule
